// File: rtl/memory_interface_bridge_pkg.sv
// Shared encodings for the LSU memory bridge: access direction, FSM states,
// the registered bus request record and the byte-lane reorder helper.
package memory_interface_bridge_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [1:0] ST_IDLE          = 2'd0;
  localparam logic [1:0] ST_REQUEST       = 2'd1;
  localparam logic [1:0] ST_WAIT_RESPONSE = 2'd2;
  localparam logic [1:0] ST_DONE          = 2'd3;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
  } bus_request_t;

  // The LSU numbers lanes big-endian (bit3 = data[7:0]); the bus wants bit i = data[8i+7:8i].
  function automatic logic [3:0] reorder_lanes(input logic [3:0] mask);
    return {mask[0], mask[1], mask[2], mask[3]};
  endfunction

endpackage

// File: rtl/memory_interface_bridge_timeout_counter.sv
// Cycle counter used by the bridge to abandon stuck bus transactions.
// Only present in builds that define BUS_TIMEOUT_EN.
`ifdef BUS_TIMEOUT_EN
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned WIDTH = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_terminal
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Count starts at zero in the first cycle of a state, so LIMIT-1 marks its LIMIT-th cycle.
  assign o_terminal = i_enable && (r_count == WIDTH'(LIMIT - 1));

endmodule
`endif

// File: rtl/memory_interface_bridge.sv
// Bridges the LSU's single-cycle memory interface onto a registered valid/ready bus.
// Define BUS_TIMEOUT_EN to abort accesses that see no accept/response within TIMEOUT_CYCLES.
module memory_interface_bridge
  import memory_interface_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_interface_enable,
  input  logic        memory_interface_memory_state,
  input  logic [31:0] memory_interface_address,
  input  logic [3:0]  memory_interface_frame_mask,
  inout  wire  [31:0] memory_interface_data,
  output logic        stall,
  output logic        bus_request_valid,
  input  logic        bus_request_ready,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic        bus_response_valid,
  input  logic [31:0] bus_read_data,
  output logic        access_fault
);

  logic [1:0]   r_state;
  logic [1:0]   w_next_state;
  bus_request_t r_req;
  logic [31:0]  r_read_data;
  logic         w_in_flight;
  logic         w_terminal;
  logic         w_timeout;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("memory_interface_bridge: TIMEOUT_CYCLES must be 1..65535");
  end

  assign w_in_flight = (r_state == ST_REQUEST) || (r_state == ST_WAIT_RESPONSE);

  // REQUEST never looks at bus_response_valid, so a response coincident with acceptance is dropped.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (memory_interface_enable) w_next_state = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (bus_request_ready) begin
          w_next_state = ST_WAIT_RESPONSE;
        end else if (w_terminal) begin
          w_next_state = ST_DONE;
          w_timeout    = 1'b1;
        end
      end
      ST_WAIT_RESPONSE: begin
        if (bus_response_valid) begin
          w_next_state = ST_DONE;
        end else if (w_terminal) begin
          w_next_state = ST_DONE;
          w_timeout    = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && memory_interface_enable) begin
        r_req.write       <= (memory_interface_memory_state == MEM_WRITE);
        r_req.address     <= memory_interface_address;
        r_req.byte_enable <= reorder_lanes(memory_interface_frame_mask);
        r_req.write_data  <= memory_interface_data;
      end
      if (r_state == ST_WAIT_RESPONSE && bus_response_valid && r_req.write == MEM_READ) begin
        r_read_data <= bus_read_data;
      end else if (w_timeout) begin
        r_read_data <= '0;
      end
    end
  end

  assign stall             = (memory_interface_enable && r_state != ST_DONE) || w_in_flight;
  assign bus_request_valid = (r_state == ST_REQUEST);
  assign bus_write         = r_req.write;
  assign bus_address       = r_req.address;
  assign bus_byte_enable   = r_req.byte_enable;
  assign bus_write_data    = r_req.write_data;

  // A flushed read (enable gone by DONE) leaves the shared data bus released.
  assign memory_interface_data =
    (r_state == ST_DONE && r_req.write == MEM_READ && memory_interface_enable)
      ? r_read_data : 32'hzzzz_zzzz;

`ifdef BUS_TIMEOUT_EN
  logic w_count_clear;
  logic r_fault;

  assign w_count_clear = (w_next_state != r_state) &&
                         (w_next_state == ST_REQUEST || w_next_state == ST_WAIT_RESPONSE);

  bus_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (w_in_flight),
    .i_clear   (w_count_clear),
    .o_terminal(w_terminal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_timeout;
    end
  end

  assign access_fault = r_fault;
`else
  assign w_terminal   = 1'b0;
  assign access_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_interface_bridge.sv
// Directed, table-driven bench for memory_interface_bridge; timeout sequence runs only
// when BUS_TIMEOUT_EN is defined.
module tb_memory_interface_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  mask = '0;
  logic        tbOe = 1'b0;
  logic [31:0] tbWd = '0;
  logic        ready = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rd = '0;
  wire  [31:0] dataBus;

  logic        stall, valid, bwrite, fault;
  logic [31:0] baddr, bwdata;
  logic [3:0]  bbe;

  int total = 0;
  int bad = 0;

  assign dataBus = tbOe ? tbWd : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  memory_interface_bridge #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .memory_interface_enable      (en),
    .memory_interface_memory_state(wr),
    .memory_interface_address     (addr),
    .memory_interface_frame_mask  (mask),
    .memory_interface_data        (dataBus),
    .stall                        (stall),
    .bus_request_valid            (valid),
    .bus_request_ready            (ready),
    .bus_write                    (bwrite),
    .bus_address                  (baddr),
    .bus_byte_enable              (bbe),
    .bus_write_data               (bwdata),
    .bus_response_valid           (rv),
    .bus_read_data                (rd),
    .access_fault                 (fault)
  );

  typedef struct {
    logic        en, wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        oe;
    logic [31:0] wd;
    logic        ready, rv;
    logic [31:0] rd;
    logic        eStall, eValid, eWrite;
    logic [31:0] eAddr;
    logic [3:0]  eBe;
    logic [31:0] eWdata;
    logic [1:0]  dChk;
    logic [31:0] eData;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ven, vwr, input logic [31:0] vaddr,
                              input logic [3:0] vmask, input logic voe, input logic [31:0] vwd,
                              input logic vready, vrv, input logic [31:0] vrd,
                              input logic s, v, w, input logic [31:0] ea, input logic [3:0] eb,
                              input logic [31:0] ewd, input logic [1:0] dk, input logic [31:0] ed);
    vec_t t;
    t.en = ven; t.wr = vwr; t.addr = vaddr; t.mask = vmask; t.oe = voe; t.wd = vwd;
    t.ready = vready; t.rv = vrv; t.rd = vrd;
    t.eStall = s; t.eValid = v; t.eWrite = w; t.eAddr = ea; t.eBe = eb; t.eWdata = ewd;
    t.dChk = dk; t.eData = ed;
    return t;
  endfunction

  task automatic applyStimulus(input logic ven, vwr, input logic [31:0] vaddr,
                               input logic [3:0] vmask, input logic voe, input logic [31:0] vwd,
                               input logic vready, vrv, input logic [31:0] vrd);
    @(negedge clk);
    en = ven; wr = vwr; addr = vaddr; mask = vmask; tbOe = voe; tbWd = vwd;
    ready = vready; rv = vrv; rd = vrd;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkNotDriven(input string name, input logic [31:0] act, input logic [31:0] forbidden);
    total++;
    if (act === forbidden) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected bus released (not %h)", name, act, forbidden);
    end
  endtask

  task automatic checkVector(input vec_t t, input int idx);
    checkOutput($sformatf("v%0d stall", idx), {31'd0, stall}, {31'd0, t.eStall});
    checkOutput($sformatf("v%0d valid", idx), {31'd0, valid}, {31'd0, t.eValid});
    checkOutput($sformatf("v%0d write", idx), {31'd0, bwrite}, {31'd0, t.eWrite});
    checkOutput($sformatf("v%0d addr", idx), baddr, t.eAddr);
    checkOutput($sformatf("v%0d be", idx), {28'd0, bbe}, {28'd0, t.eBe});
    checkOutput($sformatf("v%0d wdata", idx), bwdata, t.eWdata);
    checkOutput($sformatf("v%0d fault", idx), {31'd0, fault}, 32'd0);
    if (t.dChk == 2'd1) checkOutput($sformatf("v%0d data", idx), dataBus, t.eData);
    if (t.dChk == 2'd2) checkNotDriven($sformatf("v%0d data", idx), dataBus, t.eData);
  endtask

  initial begin
    // LW 0x100, ready high, response one cycle after accept
    vecs.push_back(mk(1,0,32'h100,4'hF,1,32'h0,1,0,32'h0,          1,0,0,32'h0,  4'h0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h100,4'hF,0,32'h0,1,0,32'h0,          1,1,0,32'h100,4'hF,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h100,4'hF,0,32'h0,0,1,32'hDEADBEEF,   1,0,0,32'h100,4'hF,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h100,4'hF,0,32'h0,0,0,32'h0,          0,0,0,32'h100,4'hF,32'h0,1,32'hDEADBEEF));
    vecs.push_back(mk(0,0,32'h0,  4'h0,0,32'h0,0,0,32'h0,          0,0,0,32'h100,4'hF,32'h0,2,32'hDEADBEEF));
    // SB mask 1000, ready low 5 cycles, bus data changes after latch, response in accept cycle
    vecs.push_back(mk(1,1,32'h204,4'h8,1,32'hA5,0,0,32'h0,         1,0,0,32'h100,4'hF,32'h0,0,32'h0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,1,32'h204,4'h8,1,32'h5A5A5A5A,0,0,32'h0, 1,1,1,32'h204,4'h1,32'hA5,0,32'h0));
    vecs.push_back(mk(1,1,32'h204,4'h8,1,32'h5A5A5A5A,1,1,32'h77777777, 1,1,1,32'h204,4'h1,32'hA5,0,32'h0));
    vecs.push_back(mk(1,1,32'h204,4'h8,0,32'h0,0,0,32'h0,          1,0,1,32'h204,4'h1,32'hA5,0,32'h0));
    vecs.push_back(mk(1,1,32'h204,4'h8,0,32'h0,0,1,32'h0,          1,0,1,32'h204,4'h1,32'hA5,0,32'h0));
    vecs.push_back(mk(1,1,32'h204,4'h8,0,32'h0,0,0,32'h0,          0,0,1,32'h204,4'h1,32'hA5,2,32'hDEADBEEF));
    vecs.push_back(mk(0,0,32'h0,  4'h0,0,32'h0,0,0,32'h0,          0,0,1,32'h204,4'h1,32'hA5,0,32'h0));
    // Two back-to-back SH mask 0011 with enable held high
    vecs.push_back(mk(1,1,32'h300,4'h3,1,32'hBEEF0000,1,0,32'h0,   1,0,1,32'h204,4'h1,32'hA5,0,32'h0));
    vecs.push_back(mk(1,1,32'h300,4'h3,0,32'h0,1,0,32'h0,          1,1,1,32'h300,4'hC,32'hBEEF0000,0,32'h0));
    vecs.push_back(mk(1,1,32'h300,4'h3,0,32'h0,0,1,32'h0,          1,0,1,32'h300,4'hC,32'hBEEF0000,0,32'h0));
    vecs.push_back(mk(1,1,32'h304,4'h3,1,32'hCAFE0000,1,0,32'h0,   0,0,1,32'h300,4'hC,32'hBEEF0000,0,32'h0));
    vecs.push_back(mk(1,1,32'h304,4'h3,1,32'hCAFE0000,1,0,32'h0,   1,0,1,32'h300,4'hC,32'hBEEF0000,0,32'h0));
    vecs.push_back(mk(1,1,32'h304,4'h3,0,32'h0,1,0,32'h0,          1,1,1,32'h304,4'hC,32'hCAFE0000,0,32'h0));
    vecs.push_back(mk(1,1,32'h304,4'h3,0,32'h0,0,1,32'h0,          1,0,1,32'h304,4'hC,32'hCAFE0000,0,32'h0));
    vecs.push_back(mk(1,1,32'h304,4'h3,0,32'h0,0,0,32'h0,          0,0,1,32'h304,4'hC,32'hCAFE0000,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,  4'h0,0,32'h0,0,0,32'h0,          0,0,1,32'h304,4'hC,32'hCAFE0000,0,32'h0));
    // Read with mask 0 is still issued, byte enable 0
    vecs.push_back(mk(1,0,32'h400,4'h0,1,32'h0,0,0,32'h0,          1,0,1,32'h304,4'hC,32'hCAFE0000,0,32'h0));
    vecs.push_back(mk(1,0,32'h400,4'h0,0,32'h0,0,0,32'h0,          1,1,0,32'h400,4'h0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h400,4'h0,0,32'h0,1,0,32'h0,          1,1,0,32'h400,4'h0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h400,4'h0,0,32'h0,0,0,32'h0,          1,0,0,32'h400,4'h0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h400,4'h0,0,32'h0,0,1,32'h12345678,   1,0,0,32'h400,4'h0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h400,4'h0,0,32'h0,0,0,32'h0,          0,0,0,32'h400,4'h0,32'h0,1,32'h12345678));
    vecs.push_back(mk(0,0,32'h0,  4'h0,0,32'h0,0,0,32'h0,          0,0,0,32'h400,4'h0,32'h0,0,32'h0));
    // Single-lane read, mask 0100 maps to byte enable 0010
    vecs.push_back(mk(1,0,32'h500,4'h4,1,32'h0,1,0,32'h0,          1,0,0,32'h400,4'h0,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h500,4'h4,0,32'h0,1,0,32'h0,          1,1,0,32'h500,4'h2,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h500,4'h4,0,32'h0,0,1,32'h0000AB00,   1,0,0,32'h500,4'h2,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,32'h500,4'h4,0,32'h0,0,0,32'h0,          0,0,0,32'h500,4'h2,32'h0,1,32'h0000AB00));
    vecs.push_back(mk(0,0,32'h0,  4'h0,0,32'h0,0,0,32'h0,          0,0,0,32'h500,4'h2,32'h0,0,32'h0));

    // Reset state
    applyStimulus(0,0,32'h0,4'h0,0,32'h0,0,0,32'h0);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset valid", {31'd0, valid}, 32'd0);
    checkOutput("reset write", {31'd0, bwrite}, 32'd0);
    checkOutput("reset addr", baddr, 32'h0);
    checkOutput("reset be", {28'd0, bbe}, 32'd0);
    checkOutput("reset wdata", bwdata, 32'h0);
    checkOutput("reset fault", {31'd0, fault}, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].mask, vecs[i].oe, vecs[i].wd,
                    vecs[i].ready, vecs[i].rv, vecs[i].rd);
      checkVector(vecs[i], i);
    end

    // Flush: enable drops while waiting for the response
    applyStimulus(1,0,32'h600,4'hF,1,32'h0,1,0,32'h0);
    checkOutput("flush idle stall", {31'd0, stall}, 32'd1);
    applyStimulus(1,0,32'h600,4'hF,0,32'h0,1,0,32'h0);
    checkOutput("flush req valid", {31'd0, valid}, 32'd1);
    applyStimulus(0,0,32'h600,4'hF,0,32'h0,0,0,32'h0);
    checkOutput("flush wait stall", {31'd0, stall}, 32'd1);
    applyStimulus(0,0,32'h600,4'hF,0,32'h0,0,1,32'hA1B2C3D4);
    checkOutput("flush resp stall", {31'd0, stall}, 32'd1);
    applyStimulus(0,0,32'h600,4'hF,0,32'h0,0,0,32'h0);
    checkOutput("flush done stall", {31'd0, stall}, 32'd0);
    checkNotDriven("flush done data", dataBus, 32'hA1B2C3D4);
    applyStimulus(0,0,32'h0,4'h0,0,32'h0,0,0,32'h0);
    checkOutput("flush idle valid", {31'd0, valid}, 32'd0);
    applyStimulus(1,0,32'h604,4'hF,1,32'h0,1,0,32'h0);
    checkOutput("post-flush idle stall", {31'd0, stall}, 32'd1);
    applyStimulus(1,0,32'h604,4'hF,0,32'h0,1,0,32'h0);
    checkOutput("post-flush req addr", baddr, 32'h604);
    applyStimulus(1,0,32'h604,4'hF,0,32'h0,0,1,32'h0F0F0F0F);
    applyStimulus(1,0,32'h604,4'hF,0,32'h0,0,0,32'h0);
    checkOutput("post-flush done stall", {31'd0, stall}, 32'd0);
    checkOutput("post-flush done data", dataBus, 32'h0F0F0F0F);
    applyStimulus(0,0,32'h0,4'h0,0,32'h0,0,0,32'h0);

    // Reset asserted mid-REQUEST
    applyStimulus(1,1,32'h700,4'hF,1,32'h11223344,0,0,32'h0);
    applyStimulus(1,1,32'h700,4'hF,0,32'h0,0,0,32'h0);
    checkOutput("pre-reset valid", {31'd0, valid}, 32'd1);
    #2;
    reset = 1'b0;
    en = 1'b0;
    #1;
    checkOutput("async reset valid", {31'd0, valid}, 32'd0);
    checkOutput("async reset stall", {31'd0, stall}, 32'd0);
    checkOutput("async reset write", {31'd0, bwrite}, 32'd0);
    checkOutput("async reset addr", baddr, 32'h0);
    checkOutput("async reset be", {28'd0, bbe}, 32'd0);
    checkOutput("async reset wdata", bwdata, 32'h0);
    applyStimulus(0,0,32'h0,4'h0,0,32'h0,0,0,32'h0);
    applyStimulus(0,0,32'h0,4'h0,0,32'h0,0,0,32'h0);
    reset = 1'b1;
    applyStimulus(1,0,32'h800,4'hF,1,32'h0,1,0,32'h0);
    checkOutput("post-reset idle stall", {31'd0, stall}, 32'd1);
    applyStimulus(1,0,32'h800,4'hF,0,32'h0,1,0,32'h0);
    checkOutput("post-reset req valid", {31'd0, valid}, 32'd1);
    checkOutput("post-reset req addr", baddr, 32'h800);
    checkOutput("post-reset req be", {28'd0, bbe}, 32'hF);
    applyStimulus(1,0,32'h800,4'hF,0,32'h0,0,1,32'h55AA55AA);
    applyStimulus(1,0,32'h800,4'hF,0,32'h0,0,0,32'h0);
    checkOutput("post-reset done stall", {31'd0, stall}, 32'd0);
    checkOutput("post-reset done data", dataBus, 32'h55AA55AA);
    applyStimulus(0,0,32'h0,4'h0,0,32'h0,0,0,32'h0);

`ifdef BUS_TIMEOUT_EN
    // No response: four WAIT_RESPONSE cycles, then a faulting DONE with zero data
    applyStimulus(1,0,32'h900,4'hF,1,32'h0,1,0,32'h0);
    applyStimulus(1,0,32'h900,4'hF,0,32'h0,1,0,32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1,0,32'h900,4'hF,0,32'h0,0,0,32'h0);
      checkOutput($sformatf("timeout wait%0d stall", i), {31'd0, stall}, 32'd1);
      checkOutput($sformatf("timeout wait%0d fault", i), {31'd0, fault}, 32'd0);
    end
    applyStimulus(1,0,32'h900,4'hF,0,32'h0,0,0,32'h0);
    checkOutput("timeout done fault", {31'd0, fault}, 32'd1);
    checkOutput("timeout done stall", {31'd0, stall}, 32'd0);
    checkOutput("timeout done data", dataBus, 32'h0);
    applyStimulus(0,0,32'h0,4'h0,0,32'h0,0,1,32'hDEADDEAD);
    checkOutput("late resp fault", {31'd0, fault}, 32'd0);
    checkOutput("late resp stall", {31'd0, stall}, 32'd0);
    applyStimulus(0,0,32'h0,4'h0,0,32'h0,0,0,32'h0);
    checkOutput("late resp valid", {31'd0, valid}, 32'd0);
    checkOutput("late resp fault2", {31'd0, fault}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_interface_bridge.md
Name: memory_interface_bridge

Overview:
- Sits directly downstream of the load/store unit's memory interface (enable, read/write state, word address, frame mask, bidirectional data).
- Converts that combinational, single-cycle-looking interface into a registered valid/ready request plus response bus toward memory or the interconnect.
- Stalls the pipeline until the access completes.
- Reorders the frame mask into little-endian bus byte enables and returns read data onto the shared data bus.

Parameters:
- TIMEOUT_CYCLES, 255: cycles waited for accept or response before faulting (only used with BUS_TIMEOUT_EN); range 1..65535.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- memory_interface_enable  input  1  access requested this cycle
- memory_interface_memory_state  input  1  0 = READ, 1 = WRITE
- memory_interface_address  input  32  word-aligned address (bits [1:0] are 00)
- memory_interface_frame_mask  input  4  lane mask; bit3 = data[7:0] … bit0 = data[31:24]
- memory_interface_data  inout  32  write data in; read data driven out in DONE for reads, else Z
- stall  output  1  hold the pipeline
- bus_request_valid  output  1  request valid
- bus_request_ready  input  1  request accepted when valid & ready
- bus_write  output  1  1 = write
- bus_address  output  32  registered address
- bus_byte_enable  output  4  bit i = data[8i+7:8i]
- bus_write_data  output  32  registered write data
- bus_response_valid  input  1  one pulse per accepted request (read data or write ack)
- bus_read_data  input  32  valid with bus_response_valid
- access_fault  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, active-low): state = IDLE.
  - bus_request_valid, bus_write, stall, access_fault = 0.
  - bus_address, bus_byte_enable, bus_write_data, read-data register = 0.
  - memory_interface_data = Z.
- FSM states: IDLE, REQUEST, WAIT_RESPONSE, DONE.
- IDLE, on enable = 1:
  - Latch address, state, write data (sampled from memory_interface_data), and mask.
  - bus_byte_enable = {mask[0], mask[1], mask[2], mask[3]}.
  - Go to REQUEST.
  - A mask of 0 is still issued, with byte_enable 0.
- REQUEST:
  - bus_request_valid = 1.
  - All bus_* request fields are held stable until valid & ready; then go to WAIT_RESPONSE.
  - Valid is never withdrawn before acceptance.
- WAIT_RESPONSE:
  - On bus_response_valid, capture bus_read_data (reads only) and go to DONE.
  - A response arriving in the same cycle as acceptance is a protocol violation and is ignored; the bus guarantees a response no earlier than the cycle after acceptance.
- DONE:
  - One cycle.
  - For a read, drive memory_interface_data with the captured word (full word; the LSU selects lanes).
  - Return to IDLE.
- stall (combinational):
  - stall = enable & (state != DONE).
  - Also stall = 1 whenever state != IDLE and != DONE, regardless of enable.
- Latency:
  - Minimum 4 cycles from enable to release: IDLE → REQUEST (ready high) → WAIT_RESPONSE (response) → DONE.
  - stall is high 3 cycles and low in DONE.
- Enable dropping mid-transaction (pipeline flush):
  - The transaction completes on the bus and the result is discarded.
  - Data is not driven in DONE if enable = 0.
- New enable while busy: stall stays high; the new access is latched only from IDLE.
- Back-to-back accesses: IDLE is re-entered for one cycle between transactions; no request overlap, at most one outstanding.
- Reset mid-transaction: immediate return to IDLE with valid low; the bus side must tolerate an abandoned request.
- Write data is latched once in IDLE; later changes on the data bus are ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A cycle counter of width ceil(log2(TIMEOUT_CYCLES+1)) clears on entering REQUEST or WAIT_RESPONSE.
  - It increments each cycle spent in either state.
  - When it reaches TIMEOUT_CYCLES, go to DONE and pulse access_fault for that DONE cycle; read data = 32'h0.
  - A late response from the bus is dropped while in IDLE.
- Undefined: no counter; access_fault is tied 0; the bridge waits indefinitely.

Decomposition:
- Shared header memory_bus_defines.vh holds:
  - READ/WRITE encodings.
  - FSM state encodings (2-bit: IDLE = 0, REQUEST = 1, WAIT_RESPONSE = 2, DONE = 3).
  - A byte-lane reorder function shared with future bus masters.
- One sub-module, bus_timeout_counter (enable, clear, terminal-count output), instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- LW @ 0x0000_0100, ready = 1, response 1 cycle after accept with 0xDEADBEEF:
  - Request shows address 0x100, byte_enable 1111, write 0.
  - stall high 3 cycles.
  - memory_interface_data = 0xDEADBEEF in DONE.
- SB, mask 1000, data 0x0000_00A5, ready held low 5 cycles:
  - valid and fields stable for all 6 cycles.
  - byte_enable 0001, bus_write_data 0x0000_00A5, write 1.
  - stall released only after the write ack.
- SH, mask 0011:
  - byte_enable 1100; two back-to-back accesses are separated by exactly one IDLE cycle, with one outstanding request.
- Flush: enable drops in WAIT_RESPONSE:
  - Response is consumed, data bus stays Z in DONE, FSM returns to IDLE, next enable is served normally.
- Reset asserted in REQUEST:
  - valid falls asynchronously, all outputs take reset values, and the first access after reset completes correctly.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no response:
  - After 4 cycles in WAIT_RESPONSE, access_fault pulses 1 cycle, read data 0x0, stall released.
  - The late response is ignored.
